// File: rtl/fft_input_loader.sv
// fft_input_loader: streams samples into the four FFT input banks, pulses start, waits for completion.
// Define FFT_LOAD_DIGIT_REV_EN to write frames in base-4 digit-reversed order.
module fft_input_loader #(
    parameter int N_POINTS = 2048,
    parameter int ADDR_W   = 9,
    parameter int DATA_W   = 16
) (
    input  logic              iCLK,
    input  logic              iRESET,
    input  logic [DATA_W-1:0] iDATA,
    input  logic              iVALID,
    output logic              oREADY,
    input  logic              iFFT_RDY,
    output logic [DATA_W-1:0] oDATA,
    output logic [ADDR_W-1:0] oADDR_WR_0,
    output logic [ADDR_W-1:0] oADDR_WR_1,
    output logic [ADDR_W-1:0] oADDR_WR_2,
    output logic [ADDR_W-1:0] oADDR_WR_3,
    output logic              oWE_0,
    output logic              oWE_1,
    output logic              oWE_2,
    output logic              oWE_3,
    output logic              oSTART,
    output logic              oBUSY,
    output logic              oOVERRUN
);
    localparam int log2_n = $clog2(N_POINTS);
    localparam logic [log2_n-1:0] last_n = log2_n'(N_POINTS - 1);

    typedef enum logic [1:0] {IDLE, LOAD, START, WAIT} state_t;

    state_t            state, next_state;
    logic [log2_n-1:0] n, idx;
    logic [ADDR_W-1:0] addr [4];
    logic [3:0]        we;
    logic              accept;

    assign accept = iVALID & oREADY;

    always_ff @(posedge iCLK or posedge iRESET)
        if (iRESET) state <= IDLE;
        else        state <= next_state;

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = LOAD;
            LOAD:    if (accept && n == last_n) next_state = START;
            START:   next_state = WAIT;
            WAIT:    if (iFFT_RDY) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        oSTART = state == START;
        oBUSY  = state != IDLE;
    end

    // Ready is registered from the upcoming state so it never depends on iVALID.
    always_ff @(posedge iCLK or posedge iRESET)
        if (iRESET) oREADY <= 1'b0;
        else        oREADY <= next_state == IDLE || next_state == LOAD;

    always_ff @(posedge iCLK or posedge iRESET)
        if (iRESET)                  n <= '0;
        else if (next_state == IDLE) n <= '0;
        else if (accept)             n <= n + 1'b1;

    always_comb begin
        idx = n;
`ifdef FFT_LOAD_DIGIT_REV_EN
        for (int i = 0; i < log2_n / 2; i++)
            idx[2*i +: 2] = n[2*(log2_n/2 - 1 - i) +: 2];
`endif
    end

    always_ff @(posedge iCLK or posedge iRESET)
        if (iRESET) begin
            oDATA <= '0;
            we    <= '0;
            addr  <= '{default: '0};
        end else begin
            we <= accept ? 4'(1) << idx[1:0] : 4'(0);
            if (accept) begin
                oDATA          <= iDATA;
                addr[idx[1:0]] <= ADDR_W'(idx >> 2);
            end
        end

    always_ff @(posedge iCLK or posedge iRESET)
        if (iRESET)                      oOVERRUN <= 1'b0;
        else if (state == WAIT && iVALID) oOVERRUN <= 1'b1;

    assign {oWE_3, oWE_2, oWE_1, oWE_0} = we;
    assign oADDR_WR_0 = addr[0];
    assign oADDR_WR_1 = addr[1];
    assign oADDR_WR_2 = addr[2];
    assign oADDR_WR_3 = addr[3];
endmodule

// File: tb/tb_fft_input_loader.sv
// tb_fft_input_loader: directed checks of fft_input_loader with a 16-point frame.
module tb_fft_input_loader;
    localparam int N = 16;
    localparam int AW = 4;
    localparam int DW = 16;

    logic          iCLK = 1'b0;
    logic          iRESET = 1'b1;
    logic [DW-1:0] iDATA = '0;
    logic          iVALID = 1'b0;
    logic          iFFT_RDY = 1'b0;
    logic          oREADY, oSTART, oBUSY, oOVERRUN;
    logic          oWE_0, oWE_1, oWE_2, oWE_3;
    logic [DW-1:0] oDATA;
    logic [AW-1:0] oADDR_WR_0, oADDR_WR_1, oADDR_WR_2, oADDR_WR_3;

    int checks = 0;
    int errors = 0;
    int start_cnt = 0;
    int we_cnt = 0;

    fft_input_loader #(.N_POINTS(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .iCLK(iCLK), .iRESET(iRESET), .iDATA(iDATA), .iVALID(iVALID), .oREADY(oREADY),
        .iFFT_RDY(iFFT_RDY), .oDATA(oDATA),
        .oADDR_WR_0(oADDR_WR_0), .oADDR_WR_1(oADDR_WR_1),
        .oADDR_WR_2(oADDR_WR_2), .oADDR_WR_3(oADDR_WR_3),
        .oWE_0(oWE_0), .oWE_1(oWE_1), .oWE_2(oWE_2), .oWE_3(oWE_3),
        .oSTART(oSTART), .oBUSY(oBUSY), .oOVERRUN(oOVERRUN)
    );

    always #5 iCLK = ~iCLK;

    always @(negedge iCLK) begin
        if (oSTART) start_cnt++;
        we_cnt += 32'(oWE_0) + 32'(oWE_1) + 32'(oWE_2) + 32'(oWE_3);
    end

    // Write index: natural order, or 2-digit base-4 reversal for 16 points.
    function automatic int widx(int n);
`ifdef FFT_LOAD_DIGIT_REV_EN
        return ((n & 3) << 2) | (n >> 2);
`else
        return n;
`endif
    endfunction

    function automatic logic [AW-1:0] bank_addr(int b);
        case (b)
            0:       return oADDR_WR_0;
            1:       return oADDR_WR_1;
            2:       return oADDR_WR_2;
            default: return oADDR_WR_3;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_write(input int n, input int d, input bit last);
        int r = widx(n);
        chk("we", 32'({oWE_3, oWE_2, oWE_1, oWE_0}), 32'(1) << (r & 3));
        chk("addr", 32'(bank_addr(r & 3)), 32'(r >> 2));
        chk("data", 32'(oDATA), 32'(d));
        chk("start", 32'(oSTART), 32'(last));
    endtask

    task automatic chk_reset_vals();
        chk("rst_ready", 32'(oREADY), 0);
        chk("rst_data", 32'(oDATA), 0);
        chk("rst_we", 32'({oWE_3, oWE_2, oWE_1, oWE_0}), 0);
        chk("rst_addr", 32'({oADDR_WR_3, oADDR_WR_2, oADDR_WR_1, oADDR_WR_0}), 0);
        chk("rst_start", 32'(oSTART), 0);
        chk("rst_busy", 32'(oBUSY), 0);
        chk("rst_overrun", 32'(oOVERRUN), 0);
    endtask

    initial begin
        int n;
        int c;
        bit v;
        bit spur;
        repeat (3) @(posedge iCLK);
        #1;
        chk_reset_vals();
        iRESET = 1'b0;
        @(posedge iCLK); #1;
        chk("ready_after_reset", 32'(oREADY), 1);
        chk("busy_idle", 32'(oBUSY), 0);

        // Frame A: unstalled natural load.
        for (int i = 0; i < N; i++) begin
            iVALID = 1'b1;
            iDATA = 16'(32'h100 + i);
            @(posedge iCLK); #1;
            chk_write(i, 32'h100 + i, i == N - 1);
            chk("busy_load", 32'(oBUSY), 1);
        end
        chk("ready_in_start", 32'(oREADY), 0);

        // Hold iVALID through WAIT: refused, overrun set from the second WAIT cycle.
        for (int k = 0; k < 5; k++) begin
            @(posedge iCLK); #1;
            chk("wait_ready", 32'(oREADY), 0);
            chk("wait_we", 32'({oWE_3, oWE_2, oWE_1, oWE_0}), 0);
            chk("wait_start", 32'(oSTART), 0);
            chk("wait_overrun", 32'(oOVERRUN), 32'(k >= 1));
        end
        chk("frameA_starts", 32'(start_cnt), 1);
        chk("frameA_writes", 32'(we_cnt), 16);
        iVALID = 1'b0;
        iFFT_RDY = 1'b1;
        @(posedge iCLK); #1;
        iFFT_RDY = 1'b0;
        chk("ready_after_fft_rdy", 32'(oREADY), 1);
        chk("busy_after_fft_rdy", 32'(oBUSY), 0);

        // Frame B: stall pattern 1,0,0,1 with a spurious iFFT_RDY at n=5.
        n = 0;
        c = 0;
        spur = 1'b0;
        while (n < N && c < 100) begin
            v = (c % 4 == 0) || (c % 4 == 3);
            iVALID = v;
            iDATA = 16'(32'h200 + n);
            if (n == 5 && !spur) begin
                iFFT_RDY = 1'b1;
                spur = 1'b1;
            end
            @(posedge iCLK); #1;
            iFFT_RDY = 1'b0;
            if (v) begin
                chk_write(n, 32'h200 + n, n == N - 1);
                n++;
            end else begin
                chk("stall_we", 32'({oWE_3, oWE_2, oWE_1, oWE_0}), 0);
                chk("stall_start", 32'(oSTART), 0);
            end
            c++;
        end
        iVALID = 1'b0;
        chk("frameB_done", 32'(n), 16);
        @(posedge iCLK); #1;
        chk("frameB_wait_ready", 32'(oREADY), 0);
        chk("overrun_sticky", 32'(oOVERRUN), 1);
        chk("frameB_starts", 32'(start_cnt), 2);
        chk("frameB_writes", 32'(we_cnt), 32);
        iFFT_RDY = 1'b1;
        @(posedge iCLK); #1;
        iFFT_RDY = 1'b0;
        chk("frameB_ready_back", 32'(oREADY), 1);

        // Reset after 7 samples of frame C.
        for (int i = 0; i < 7; i++) begin
            iVALID = 1'b1;
            iDATA = 16'(32'h300 + i);
            @(posedge iCLK); #1;
            chk_write(i, 32'h300 + i, 1'b0);
        end
        iVALID = 1'b0;
        iRESET = 1'b1;
        #1;
        chk_reset_vals();
        @(posedge iCLK);
        @(posedge iCLK); #1;
        iRESET = 1'b0;
        @(posedge iCLK); #1;
        chk("ready_after_midreset", 32'(oREADY), 1);
        iVALID = 1'b1;
        iDATA = 16'h3aa;
        @(posedge iCLK); #1;
        chk_write(0, 32'h3aa, 1'b0);
        iVALID = 1'b0;
        repeat (3) @(posedge iCLK);
        #1;
        chk("no_start_after_reset", 32'(start_cnt), 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
